// File: rtl/regfile_alu_pkg.sv
// regfile_alu_pkg
//   Shared types and defaults for the register-file ALU sequencer.
//   - state_t : sequencer FSM states (IDLE, READ, EXEC, WRITE, FIN)
//   - op_t    : ALU operation codes (ADD, SUB, AND, XOR)
//   - DEF_*   : default data / address widths of the 4x4 register file
package regfile_alu_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_RADDR_W = 2;
    localparam int DEF_WADDR_W = 3;

    // IDLE must encode as 0 so that reset lands there.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_t;

endpackage

// File: rtl/regfile_alu_sequencer_alu_core.sv
// alu_core
//   Combinational 4-function ALU used by the sequencer's EXEC state.
//   Ports:
//     i_op    in  2      operation code (op_t encoding)
//     i_a     in  WIDTH  first operand (P)
//     i_b     in  WIDTH  second operand (Q)
//     o_res   out WIDTH  result, mod 2^WIDTH
//     o_carry out 1      ADD carry-out / SUB borrow; only with ALU_FLAGS_EN
//   Configuration macro: ALU_FLAGS_EN (adds o_carry).
module alu_core
    import regfile_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef ALU_FLAGS_EN
    output logic             o_carry,
`endif
    output logic [WIDTH-1:0] o_res
);

    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;

`ifdef ALU_FLAGS_EN
    // One extra bit: MSB of the sum is carry-out, MSB of the difference is borrow.
    logic [WIDTH:0] w_sum_x;
    logic [WIDTH:0] w_dif_x;

    assign w_sum_x = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif_x = {1'b0, i_a} - {1'b0, i_b};
    assign w_add   = w_sum_x[WIDTH-1:0];
    assign w_sub   = w_dif_x[WIDTH-1:0];

    always_comb begin
        o_carry = 1'b0;
        case (op_t'(i_op))
            OP_ADD:  o_carry = w_sum_x[WIDTH];
            OP_SUB:  o_carry = w_dif_x[WIDTH];
            default: o_carry = 1'b0;
        endcase
    end
`else
    assign w_add = i_a + i_b;
    assign w_sub = i_a - i_b;
`endif

    always_comb begin
        o_res = '0;
        case (op_t'(i_op))
            OP_ADD:  o_res = w_add;
            OP_SUB:  o_res = w_sub;
            OP_AND:  o_res = i_a & i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/regfile_alu_sequencer.sv
// regfile_alu_sequencer
//   Read-execute-writeback sequencer for a 4x4 register file. One ALU op per
//   START: drive P/Q read addresses, latch DATAP/DATAQ, compute, write back.
//   Ports:
//     CLK, CLR          clock (rising edge), async active-high reset
//     START             op request, sampled only in IDLE
//     OP/SRC_P/SRC_Q/DST op fields, captured once at the IDLE->READ edge
//     DATAP, DATAQ      combinational read data from the register file
//     RP, RQ            read addresses (READ and EXEC, else 0)
//     WA, WR, LD_DATA   write port (WRITE only, else 0); WR=~DST[2]
//     BUSY              high in every state but IDLE
//     DONE              one-cycle pulse in FIN
//     CARRY, ZERO       ALU flags, updated in EXEC; only with ALU_FLAGS_EN
//   Configuration macro: ALU_FLAGS_EN.
module regfile_alu_sequencer
    import regfile_alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int WADDR_W = DEF_WADDR_W
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               START,
    input  logic [1:0]         OP,
    input  logic [RADDR_W-1:0] SRC_P,
    input  logic [RADDR_W-1:0] SRC_Q,
    input  logic [WADDR_W-1:0] DST,
    input  logic [WIDTH-1:0]   DATAP,
    input  logic [WIDTH-1:0]   DATAQ,
    output logic [RADDR_W-1:0] RP,
    output logic [RADDR_W-1:0] RQ,
    output logic [WADDR_W-1:0] WA,
    output logic               WR,
    output logic [WIDTH-1:0]   LD_DATA,
`ifdef ALU_FLAGS_EN
    output logic               CARRY,
    output logic               ZERO,
`endif
    output logic               BUSY,
    output logic               DONE
);

    state_t               r_state;
    state_t               w_next;

    logic [1:0]           r_op;
    logic [WADDR_W-1:0]   r_dst;
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;
    logic [RADDR_W-1:0]   r_rp;
    logic [RADDR_W-1:0]   r_rq;
    logic [WADDR_W-1:0]   r_wa;
    logic                 r_wr;
    logic [WIDTH-1:0]     r_result;
    logic                 r_done;
    logic [WIDTH-1:0]     w_alu;

`ifdef ALU_FLAGS_EN
    logic                 w_carry;
    logic                 r_carry;
    logic                 r_zero;
`endif

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .i_op    (r_op),
        .i_a     (r_opa),
        .i_b     (r_opb),
`ifdef ALU_FLAGS_EN
        .o_carry (w_carry),
`endif
        .o_res   (w_alu)
    );

    // State register
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state; no waiting anywhere once an op is accepted
    always_comb begin
        w_next = r_state;
        BUSY   = (r_state != IDLE);
        case (r_state)
            IDLE:    if (START) w_next = READ;
            READ:    w_next = EXEC;
            EXEC:    w_next = WRITE;
            WRITE:   w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and registered outputs. Each output register is loaded on the
    // edge that enters its active state and cleared on the edge that leaves
    // it, so the pins never glitch and read 0 outside their window.
    // r_result doubles as the LD_DATA register: it only carries the result
    // while the write is being presented.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_op     <= '0;
            r_dst    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_rp     <= '0;
            r_rq     <= '0;
            r_wa     <= '0;
            r_wr     <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
`endif
        end else begin
            r_wa     <= '0;
            r_wr     <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_op  <= OP;
                        r_dst <= DST;
                        r_rp  <= SRC_P;
                        r_rq  <= SRC_Q;
                    end
                end
                READ: begin
                    // Operands are latched here, before any write of this op,
                    // so SRC==DST reads the old value.
                    r_opa <= DATAP;
                    r_opb <= DATAQ;
                end
                EXEC: begin
                    r_rp     <= '0;
                    r_rq     <= '0;
                    r_wa     <= r_dst;
                    r_wr     <= ~r_dst[WADDR_W-1];
                    r_result <= w_alu;
`ifdef ALU_FLAGS_EN
                    r_carry  <= w_carry;
                    r_zero   <= (w_alu == '0);
`endif
                end
                WRITE: r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign RP      = r_rp;
    assign RQ      = r_rq;
    assign WA      = r_wa;
    assign WR      = r_wr;
    assign LD_DATA = r_result;
    assign DONE    = r_done;
`ifdef ALU_FLAGS_EN
    assign CARRY   = r_carry;
    assign ZERO    = r_zero;
`endif

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// tb_regfile_alu_sequencer
//   Bench for regfile_alu_sequencer with a behavioural 4x4 register file.
//   Table-driven vectors, hand sequences for START-held, CLR-mid-op and
//   back-to-back ordering, then random ops against a shadow copy of the file.
//   Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_regfile_alu_sequencer;
    import regfile_alu_pkg::*;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       START;
    logic [1:0] OP;
    logic [1:0] SRC_P, SRC_Q;
    logic [2:0] DST;
    logic [3:0] DATAP, DATAQ;
    logic [1:0] RP, RQ;
    logic [2:0] WA;
    logic       WR;
    logic [3:0] LD_DATA;
    logic       BUSY, DONE;
`ifdef ALU_FLAGS_EN
    logic       CARRY, ZERO;
`endif

    regfile_alu_sequencer dut (
        .CLK(CLK), .CLR(CLR), .START(START), .OP(OP),
        .SRC_P(SRC_P), .SRC_Q(SRC_Q), .DST(DST),
        .DATAP(DATAP), .DATAQ(DATAQ),
        .RP(RP), .RQ(RQ), .WA(WA), .WR(WR), .LD_DATA(LD_DATA),
`ifdef ALU_FLAGS_EN
        .CARRY(CARRY), .ZERO(ZERO),
`endif
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Behavioural register file: combinational read, write on rising edge.
    logic [3:0] rf [4];
    logic       pl_en;
    logic [3:0] pl_v [4];
    always @(posedge CLK) begin
        if (pl_en) begin
            for (int i = 0; i < 4; i++) rf[i] <= pl_v[i];
        end else if (WR) begin
            rf[WA[1:0]] <= LD_DATA;
        end
    end
    assign DATAP = rf[RP];
    assign DATAQ = rf[RQ];

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] ref_rf [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int r;
        case (op)
            2'd0:    r = (int'(a) + int'(b)) % 16;
            2'd1:    r = (int'(a) - int'(b) + 16) % 16;
            2'd2:    r = int'(a & b);
            default: r = int'(a ^ b);
        endcase
        return r[3:0];
    endfunction

    function automatic logic cy_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        if (op == 2'd0) return (int'(a) + int'(b)) > 15;
        if (op == 2'd1) return int'(a) < int'(b);
        return 1'b0;
    endfunction

    // Expected {BUSY,DONE,WR,RP,RQ,WA,LD_DATA} in cycle k after the START edge.
    function automatic logic [13:0] exp_tup(input int k, input logic [1:0] p, input logic [1:0] q,
                                            input logic [2:0] dst, input logic [3:0] res);
        case (k)
            1, 2:    return {1'b1, 1'b0, 1'b0, p, q, 3'b000, 4'h0};
            3:       return {1'b1, 1'b0, ~dst[2], 2'b00, 2'b00, dst, res};
            default: return {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 4'h0};
        endcase
    endfunction

    function automatic logic [15:0] rf_vec();
        return {rf[3], rf[2], rf[1], rf[0]};
    endfunction

    function automatic logic [15:0] ref_vec();
        return {ref_rf[3], ref_rf[2], ref_rf[1], ref_rf[0]};
    endfunction

    task automatic preload(input logic [15:0] v);
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            pl_v[i]   = v[i*4 +: 4];
            ref_rf[i] = v[i*4 +: 4];
        end
        pl_en = 1'b1;
        @(posedge CLK);
        #1 pl_en = 1'b0;
    endtask

    // Issue one op, check every cycle until DONE, then the file contents.
    task automatic do_op(input string nm, input logic [1:0] op, input logic [1:0] p,
                         input logic [1:0] q, input logic [2:0] dst, input logic [3:0] res,
                         input logic cy, input logic z);
        @(negedge CLK);
        START = 1'b1; OP = op; SRC_P = p; SRC_Q = q; DST = dst;
        @(posedge CLK);
        #1;
        // Fields must have been captured; scramble them.
        START = 1'b0; OP = 2'($urandom); SRC_P = 2'($urandom);
        SRC_Q = 2'($urandom); DST = 3'($urandom);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            chk($sformatf("%s cyc%0d", nm, k), {18'd0, BUSY, DONE, WR, RP, RQ, WA, LD_DATA},
                {18'd0, exp_tup(k, p, q, dst, res)});
        end
        if (!dst[2]) ref_rf[dst[1:0]] = res;
        chk($sformatf("%s rf", nm), {16'd0, rf_vec()}, {16'd0, ref_vec()});
`ifdef ALU_FLAGS_EN
        chk($sformatf("%s carry", nm), {31'd0, CARRY}, {31'd0, cy});
        chk($sformatf("%s zero", nm), {31'd0, ZERO}, {31'd0, z});
`else
        if (cy === 1'bx || z === 1'bx) $display("note: %s flag expectation undefined", nm);
`endif
    endtask

    typedef struct {
        logic [1:0]  op, p, q;
        logic [2:0]  dst;
        logic [15:0] pre;   // {R3,R2,R1,R0}
        logic [3:0]  res;
        logic        cy, z;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [15:0] mask;
        logic        bad;
        logic [1:0]  op, p, q;
        logic [2:0]  dst;
        logic [3:0]  res;

        vt[0] = '{2'd0, 2'd1, 2'd2, 3'd3, 16'h0530, 4'h8, 1'b0, 1'b0}; // ADD 3+5 -> R3
        vt[1] = '{2'd1, 2'd0, 2'd1, 3'd0, 16'h0032, 4'hF, 1'b1, 1'b0}; // SUB 2-3 wraps
        vt[2] = '{2'd3, 2'd2, 2'd2, 3'd4, 16'h0A00, 4'h0, 1'b0, 1'b1}; // XOR, no write
        vt[3] = '{2'd0, 2'd0, 2'd1, 3'd1, 16'h001F, 4'h0, 1'b1, 1'b1}; // ADD F+1 wraps
        vt[4] = '{2'd2, 2'd2, 2'd3, 3'd7, 16'h6C00, 4'h4, 1'b0, 1'b0}; // AND, no write
        vt[5] = '{2'd1, 2'd1, 2'd0, 3'd1, 16'h0095, 4'h4, 1'b0, 1'b0}; // SUB 9-5
        vt[6] = '{2'd3, 2'd3, 2'd1, 3'd2, 16'h9060, 4'hF, 1'b0, 1'b0}; // XOR 9^6
        vt[7] = '{2'd1, 2'd2, 2'd2, 3'd2, 16'h0700, 4'h0, 1'b0, 1'b1}; // SRC==DST

        pl_en = 1'b0; START = 1'b0; OP = 2'd0; SRC_P = 2'd0; SRC_Q = 2'd0; DST = 3'd0;
        for (int i = 0; i < 4; i++) pl_v[i] = 4'h0;
        CLR = 1'b1;
        #3;
        chk("reset outputs", {18'd0, BUSY, DONE, WR, RP, RQ, WA, LD_DATA}, 32'd0);
`ifdef ALU_FLAGS_EN
        chk("reset flags", {30'd0, CARRY, ZERO}, 32'd0);
`endif
        repeat (2) @(negedge CLK);
        CLR = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            preload(vt[i].pre);
            do_op($sformatf("vec%0d", i), vt[i].op, vt[i].p, vt[i].q, vt[i].dst,
                  vt[i].res, vt[i].cy, vt[i].z);
        end

        // START held high across 10 edges: two ops, DONE at cycles 4 and 9,
        // second op uses the fields present at its own IDLE edge.
        preload(16'h0530);
        @(negedge CLK);
        START = 1'b1; OP = 2'd0; SRC_P = 2'd1; SRC_Q = 2'd2; DST = 3'd3;
        @(posedge CLK);
        #1 OP = 2'd3; SRC_P = 2'd1; SRC_Q = 2'd2; DST = 3'd0;
        mask = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (DONE) mask[k] = 1'b1;
            if (k == 9) START = 1'b0;
        end
        chk("held START done cycles", {16'd0, mask}, 32'h0000_0210);
        ref_rf[3] = 4'h8; ref_rf[0] = 4'h6;
        chk("held START rf", {16'd0, rf_vec()}, 32'h0000_8536);

        // CLR during WRITE: WR drops at once, no write, no DONE.
        preload(16'h9421);
        @(negedge CLK);
        START = 1'b1; OP = 2'd0; SRC_P = 2'd0; SRC_Q = 2'd1; DST = 3'd3;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre-CLR WR", {31'd0, WR}, 32'd1);
        CLR = 1'b1;
        #1;
        chk("CLR outputs", {18'd0, BUSY, DONE, WR, RP, RQ, WA, LD_DATA}, 32'd0);
`ifdef ALU_FLAGS_EN
        chk("CLR flags", {30'd0, CARRY, ZERO}, 32'd0);
`endif
        @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0) bad = 1'b1;
        end
        chk("post-CLR quiet", {31'd0, bad}, 32'd0);
        chk("post-CLR rf", {16'd0, rf_vec()}, 32'h0000_9421);

        // Back-to-back: A writes R1=7, B reads R1 in the following READ.
        preload(16'h0007);
        do_op("b2b A", 2'd0, 2'd0, 2'd2, 3'd1, 4'h7, 1'b0, 1'b0);
        do_op("b2b B", 2'd2, 2'd1, 2'd1, 3'd2, 4'h7, 1'b0, 1'b0);
        chk("b2b R2", {28'd0, rf[2]}, 32'd7);

        // Random ops against the shadow copy of the file
        preload(16'($urandom));
        for (int n = 0; n < 40; n++) begin
            op  = 2'($urandom);
            p   = 2'($urandom);
            q   = 2'($urandom);
            dst = 3'($urandom_range(0, 7));
            res = alu_ref(op, ref_rf[p], ref_rf[q]);
            do_op($sformatf("rnd%0d", n), op, p, q, dst, res,
                  cy_ref(op, ref_rf[p], ref_rf[q]), res == 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
